// File: rtl/distance_filter_if.sv
// distance_filter_if: raw sample input and filtered outputs of distance_filter.
interface distance_filter_if;
  logic       distance_valid;
  logic [7:0] distance;
  logic [7:0] avg_distance;
  logic       avg_valid;
  logic       obstacle;
  logic       stale;
  modport master (output distance_valid, distance, input avg_distance, avg_valid, obstacle, stale);
  modport slave (input distance_valid, distance, output avg_distance, avg_valid, obstacle, stale);
endinterface

// File: rtl/distance_filter.sv
// distance_filter: moving-average distance smoother with hysteretic obstacle flag and sensor watchdog.
// Outlier rejection is compiled in when OUTLIER_REJECT_EN is defined.
module distance_filter #(
  parameter int LOG2_DEPTH     = 3,
  parameter int NEAR_CM        = 20,
  parameter int FAR_CM         = 30,
  parameter int TIMEOUT_CYCLES = 10_000_000
`ifdef OUTLIER_REJECT_EN
  , parameter int MAX_JUMP     = 40
`endif
) (
  input logic clk,
  input logic rst,
  input logic clear,
  distance_filter_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW = 8 + LOG2_DEPTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] NEAR = 8'(NEAR_CM);
  localparam logic [7:0] FAR = 8'(FAR_CM);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic {EMPTY, RUN} state_t;
  state_t state, state_next;
  logic [7:0] buffer [DEPTH];
  logic [LOG2_DEPTH-1:0] ptr, ptr_next;
  logic [SW-1:0] sum, sum_next, sum_new;
  logic [TW-1:0] cnt, cnt_next;
  logic [7:0] avg, avg_next, avg_new;
  logic avg_valid, avg_valid_next, obstacle, obstacle_next, stale, stale_next;
  logic sample, accept, prime, reject, force_prime;
  assign sample = bus.distance_valid && bus.distance != 8'd0;
`ifdef OUTLIER_REJECT_EN
  localparam logic [7:0] JUMP = 8'(MAX_JUMP);
  logic [2:0] rejects;
  logic [7:0] diff;
  logic jump;
  always_comb begin
    diff = bus.distance >= avg ? bus.distance - avg : avg - bus.distance;
    jump = sample && state == RUN && diff > JUMP;
    reject = jump && rejects != 3'd2;
    force_prime = jump && rejects == 3'd2;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) rejects <= '0;
    else if (clear || accept) rejects <= '0;
    else if (reject) rejects <= rejects + 3'd1;
`else
  assign reject = 1'b0;
  assign force_prime = 1'b0;
`endif
  assign accept = sample && !reject;
  assign prime = accept && (state == EMPTY || force_prime);
  assign sum_new = prime ? {bus.distance, {LOG2_DEPTH{1'b0}}}
                         : sum - SW'(buffer[ptr]) + SW'(bus.distance);
  assign avg_new = sum_new[SW-1:LOG2_DEPTH];
  always_comb begin
    state_next = state;
    ptr_next = ptr;
    sum_next = sum;
    cnt_next = bus.distance_valid ? '0 : cnt == TMO ? cnt : cnt + TW'(1);
    avg_next = avg;
    avg_valid_next = 1'b0;
    obstacle_next = obstacle;
    stale_next = stale;
    if (clear) begin
      state_next = EMPTY;
      ptr_next = '0;
      sum_next = '0;
      cnt_next = '0;
      avg_next = '0;
      obstacle_next = 1'b0;
      stale_next = 1'b0;
    end else if (accept) begin
      state_next = RUN;
      ptr_next = prime ? '0 : ptr + 1'b1;
      sum_next = sum_new;
      avg_next = avg_new;
      avg_valid_next = 1'b1;
      stale_next = 1'b0;
      obstacle_next = avg_new < NEAR ? 1'b1 : avg_new >= FAR ? 1'b0 : obstacle;
    end else if (!bus.distance_valid && cnt == TMO_LAST) begin
      state_next = EMPTY;
      stale_next = 1'b1;
      obstacle_next = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      ptr <= '0;
      sum <= '0;
      cnt <= '0;
      avg <= '0;
      avg_valid <= 1'b0;
      obstacle <= 1'b0;
      stale <= 1'b0;
    end else begin
      state <= state_next;
      ptr <= ptr_next;
      sum <= sum_next;
      cnt <= cnt_next;
      avg <= avg_next;
      avg_valid <= avg_valid_next;
      obstacle <= obstacle_next;
      stale <= stale_next;
    end
  // Priming fills every slot so the running sum and the buffer always agree.
  always_ff @(posedge clk)
    if (!clear && accept)
      for (int i = 0; i < DEPTH; i++)
        if (prime || ptr == LOG2_DEPTH'(i)) buffer[i] <= bus.distance;
  assign bus.avg_distance = avg;
  assign bus.avg_valid = avg_valid;
  assign bus.obstacle = obstacle;
  assign bus.stale = stale;
endmodule

// File: doc/distance_filter.md
Name: distance_filter

Overview:
Consumes raw 8-bit distance samples from the ultrasonic sensor driver and produces a smoothed distance plus a hysteretic obstacle flag for the LED and motion-control logic. Smoothing is a power-of-two moving average built from a circular sample buffer and a running sum. A watchdog flags a stale sensor when no sample arrives in time, and forces the obstacle flag to its fail-safe value.

Parameters:
LOG2_DEPTH, 3, log2 of averaging window; window = 8 samples; legal 1..5
NEAR_CM, 20, obstacle asserts when average < NEAR_CM
FAR_CM, 30, obstacle deasserts when average >= FAR_CM; must be > NEAR_CM
TIMEOUT_CYCLES, 10_000_000, clk cycles with no distance_valid before stale (200 ms at 50 MHz)
MAX_JUMP, 40, outlier threshold in cm (used only with the optional feature)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush; returns the block to the post-reset state
distance_valid  input  1  single-cycle strobe; distance is valid this cycle
distance  input  8  raw sample in cm; 0 = no echo
avg_distance  output  8  filtered distance in cm
avg_valid  output  1  single-cycle pulse when avg_distance updates
obstacle  output  1  hysteretic proximity flag
stale  output  1  sensor-timeout flag

Behaviour:
- Reset (rst low, async) and clear (sync, highest priority after reset) put the block in these values: avg_distance=0, avg_valid=0, obstacle=0, stale=0, write pointer=0, running sum=0, state=EMPTY, timeout counter=0.
- States:
  - EMPTY: no sample accepted yet.
  - RUN: buffer holds valid data.
- Sample acceptance: a sample is accepted when distance_valid=1 and distance!=0.
  - distance=0 with distance_valid=1 is discarded.
  - A discarded sample still restarts the timeout counter.
- EMPTY + accepted sample s:
  - Every buffer entry is written to s.
  - sum = s << LOG2_DEPTH; pointer = 0.
  - Next state is RUN.
- RUN + accepted sample s:
  - sum_next = sum - buf[ptr] + s; buf[ptr] = s; ptr = ptr+1.
  - ptr wraps modulo 2^LOG2_DEPTH.
- Sum width is 8+LOG2_DEPTH bits. Overflow and underflow are impossible by construction and must never saturate.
- avg_distance = sum_next >> LOG2_DEPTH (truncating). It is registered.
- avg_valid pulses exactly 1 cycle after the accepting distance_valid, with avg_distance updated on the same edge. Latency is 1 clk.
- Obstacle hysteresis is evaluated on the new average, on the same edge as avg_valid:
  - obstacle sets if avg < NEAR_CM.
  - obstacle clears if avg >= FAR_CM.
  - Otherwise obstacle holds.
- Back-to-back distance_valid on consecutive cycles must be accepted every cycle: throughput is 1 sample per clk.
- Timeout counter:
  - Increments every cycle and saturates at TIMEOUT_CYCLES.
  - Resets to 0 on any distance_valid.
  - When it reaches TIMEOUT_CYCLES: stale=1, obstacle=1 (fail-safe), state=EMPTY.
  - avg_distance holds its last value.
- Leaving stale: the next accepted sample re-primes the buffer (EMPTY path), clears stale, and re-evaluates obstacle from the fresh average.
- Simultaneous events:
  - distance_valid wins over the timeout expiry in the same cycle: the sample is processed and stale stays 0.
  - clear wins over distance_valid.
- Reset mid-operation discards all buffered data. No partial update is visible.

Optional Feature:
OUTLIER_REJECT_EN
- Defined: in RUN, a sample with |s - avg_distance| > MAX_JUMP is rejected.
  - A rejected sample causes no buffer write and no avg_valid, but still restarts the timeout counter.
  - A 3-bit reject counter increments on each rejection.
  - The 3rd consecutive rejection is force-accepted through the EMPTY path (re-prime); the counter then clears.
  - Any normal acceptance clears the counter.
- Undefined: all nonzero samples are accepted. The reject counter and comparator are absent.

Test Plan:
- Reset, then one sample 100 -> next cycle avg_valid=1, avg_distance=100, obstacle=0, stale=0.
- Prime with 100, then 8 samples of 10 at 1/cycle -> averages 88,77,66,55,43,32,21,10. obstacle sets on the sample after which avg<20 (avg=10); none of the 8 samples is dropped.
- Obstacle set at avg 10, then feed 25s until avg reaches 25 -> obstacle holds 1. Then feed 35s until avg>=30 -> obstacle clears on that avg_valid.
- TIMEOUT_CYCLES=100, no samples for 100 cycles -> stale=1 and obstacle=1 on cycle 100. Then sample 60 -> avg_distance=60, stale=0, obstacle=0. Also check a distance_valid in the expiry cycle keeps stale=0.
- distance_valid with distance=0 -> no avg_valid, timeout counter restarted. Also assert clear and distance_valid in the same cycle -> outputs return to reset values.
- OUTLIER_REJECT_EN, avg 50, MAX_JUMP=40, samples 200,200,200 -> first two produce no avg_valid; the third re-primes to avg_distance=200.
